// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit and its return-address stack:
//   - pc_state_e : control FSM encoding (BOOT=0, RUN=1, HALT=2)
//   - RAS_ERR_*  : bit positions inside the sticky ras_err vector
//   - DEF_*      : default parameter values used by pc_unit_param
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int unsigned RAS_ERR_OVF = 0;
  localparam int unsigned RAS_ERR_UNF = 1;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;
  localparam int unsigned DEF_INC       = 4;
  localparam int unsigned DEF_ALIGN     = 2;
  localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage : pc_pkg

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack with a write pointer and a saturating count.
// A push when full overwrites the oldest entry; a pop when empty only records
// an underflow. Overflow/underflow flags are sticky until reset.
//
// Ports:
//   clk      in   core clock
//   reset    in   synchronous active-high reset
//   push     in   write din at the write pointer and advance
//   pop      in   discard the top entry (flags underflow when empty)
//   replace  in   overwrite the top entry with din, count unchanged
//   din      in   [WIDTH-1:0] address to push / replace with
//   top      out  [WIDTH-1:0] most recently pushed entry
//   empty    out  count == 0
//   full     out  count == RAS_DEPTH
//   ovf      out  sticky: a push happened while full
//   unf      out  sticky: a pop happened while empty
// -----------------------------------------------------------------------------
module ras_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    count;

  // The write pointer wraps naturally because RAS_DEPTH is a power of two.
  assign top_idx = wp - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));

  // NOTE: the entry array is deliberately left out of reset; count gates every
  // read that matters, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (replace) begin
      mem[top_idx] <= din;
    end else if (push) begin
      mem[wp] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      // An empty pop is only recorded; it may coincide with a push.
      if (pop && empty) begin
        unf <= 1'b1;
      end
      if (replace) begin
        // Net zero: the top slot is rewritten in place.
      end else if (push) begin
        wp <= wp + PW'(1);
        if (full) begin
          ovf <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end else if (pop && !empty) begin
        wp    <= top_idx;
        count <= count - CW'(1);
      end
    end
  end

endmodule : ras_stack

// File: rtl/pc_unit_param.sv
// -----------------------------------------------------------------------------
// pc_unit_param
// Program-counter unit: holds the fetch PC, selects the next PC from a
// prioritised set of sources (trap, halt, ret, call, jump, branch, stall,
// increment), owns a return-address stack and a BOOT/RUN/HALT FSM.
//
// Ports:
//   clk            in   core clock
//   reset          in   synchronous active-high reset (highest priority)
//   stall          in   hold pc (sequential increment only)
//   branch_taken   in   redirect to branch_target
//   branch_target  in   [WIDTH-1:0]
//   jump           in   redirect to jump_target
//   call           in   redirect to jump_target and push pc+INC
//   jump_target    in   [WIDTH-1:0]
//   ret            in   pop the RAS and redirect to it
//   trap           in   redirect to TRAP_VEC (also leaves HALT)
//   halt           in   enter HALT
//   resume         in   leave HALT at the same pc
//   pc             out  [WIDTH-1:0] registered fetch PC
//   pc_plus        out  [WIDTH-1:0] pc + INC (combinational, wraps)
//   pc_valid       out  registered: pc is a valid fetch address
//   ras_empty      out  RAS count == 0
//   ras_full       out  RAS count == RAS_DEPTH
//   ras_err        out  [1:0] sticky {underflow, overflow}
//   state          out  [1:0] BOOT=0, RUN=1, HALT=2
// -----------------------------------------------------------------------------
module pc_unit_param
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC),
  parameter int unsigned      INC       = DEF_INC,
  parameter int unsigned      ALIGN     = DEF_ALIGN,
  parameter int unsigned      RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  input  logic             trap,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             ras_empty,
  output logic             ras_full,
  output logic [1:0]       ras_err,
  output logic [1:0]       state
);

  // Clears the low ALIGN bits of every value loaded into pc.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN) - WIDTH'(1));

  pc_state_e        state_q;
  pc_state_e        state_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic             ras_ovf;
  logic             ras_unf;

  assign pc_plus = pc + WIDTH'(INC);
  assign state   = state_q;

  assign ras_err[RAS_ERR_OVF] = ras_ovf;
  assign ras_err[RAS_ERR_UNF] = ras_unf;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .din     (pc_plus),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf     (ras_ovf),
    .unf     (ras_unf)
  );

  // Next-PC selection. RAS commands are only issued from RUN, so BOOT and HALT
  // never disturb the stack.
  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next     = pc;
    state_next  = state_q;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (trap) begin
          pc_next = TRAP_VEC;
        end else if (halt) begin
          state_next = ST_HALT;
        end else if (ret && call) begin
          // Pop then push: on a non-empty stack this is an in-place replace;
          // on an empty one the pop underflows and the push still lands.
          pc_next = jump_target;
          if (ras_empty) begin
            ras_pop  = 1'b1;
            ras_push = 1'b1;
          end else begin
            ras_replace = 1'b1;
          end
        end else if (ret) begin
          ras_pop = 1'b1;
          pc_next = ras_empty ? pc_plus : ras_top;
        end else if (call) begin
          ras_push = 1'b1;
          pc_next  = jump_target;
        end else if (jump) begin
          pc_next = jump_target;
        end else if (branch_taken) begin
          pc_next = branch_target;
        end else if (!stall) begin
          pc_next = pc_plus;
        end
      end
      ST_HALT: begin
        if (trap) begin
          pc_next    = TRAP_VEC;
          state_next = ST_RUN;
        end else if (resume) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // Control FSM with registered outputs pc, pc_valid and state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc       <= RESET_VEC & ALIGN_MASK;
      pc_valid <= 1'b0;
    end else begin
      state_q  <= state_next;
      pc       <= pc_next & ALIGN_MASK;
      pc_valid <= (state_next == ST_RUN);
    end
  end

endmodule : pc_unit_param
